// File: rtl/rv_mem_arb.sv
// Round-robin arbiter funnelling an instruction-fetch port and a data port onto
// one memory interface, with one access outstanding and an optional wait watchdog.
module rv_mem_arb #(
  parameter int DPWIDTH = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [DPWIDTH-1:0] i_addr,
  output logic               i_ack,
  output logic [DPWIDTH-1:0] i_rdata,
  output logic               i_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic               d_ack,
  output logic [DPWIDTH-1:0] d_rdata,
  output logic               d_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DPWIDTH-1:0] mem_addr,
  output logic [DPWIDTH-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [DPWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  state_e             state_q, state_d;
  logic               last_d_q, last_d_d;   // 1: data port was granted last
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DPWIDTH-1:0] addr_q, addr_d;
  logic [DPWIDTH-1:0] wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic               d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DPWIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic i_live, d_live, grant_i, grant_d, expired;

  always_comb begin
    // A requester whose ack is on the wire this cycle still shows its old req.
    i_live  = i_req & ~i_ack_q;
    d_live  = d_req & ~d_ack_q;
    grant_d = d_live & (~i_live | ~last_d_q);
    grant_i = i_live & (~d_live | last_d_q);
    expired = (TIMEOUT != 0) && (cnt_q == TO_LIM);

    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = D_ACC;
          last_d_d = 1'b1;
          cnt_d    = '0;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
        end else if (grant_i) begin
          state_d  = I_ACC;
          last_d_d = 1'b0;
          cnt_d    = '0;
          addr_d   = i_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
        end
      end
      I_ACC, D_ACC: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (state_q == I_ACC) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
        end else if (expired) begin
          state_d = IDLE;
          if (state_q == I_ACC) begin
            i_ack_d = 1'b1;
            i_err_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q & (state_q == D_ACC);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed corner cases then randomized accesses, each
// access predicted at transaction level (owner, latency, err, returned data).
module tb_rv_mem_arb;
  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, i_ack, i_err;
  logic [W-1:0] i_addr, i_rdata;
  logic         d_req, d_we, d_ack, d_err;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  rv_mem_arb #(.DPWIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  bit           m_last_d;          // model: data port served most recently
  logic [W-1:0] m_irdata, m_drdata;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memctl"}, {29'd0, mem_req, mem_we, mem_ack & 1'b0}, '0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_ackerr"}, {28'd0, i_ack, i_err, d_ack, d_err}, '0);
    chk({tag, "_irdata"}, i_rdata, '0);
    chk({tag, "_drdata"}, d_rdata, '0);
  endtask

  // Called one ns after an edge with the requests for this access on the pins;
  // the next edge must grant own_d. The memory answers on its lat-th mem_req cycle.
  task automatic access(input bit own_d, input int lat, input logic [W-1:0] rd, input bit scramble);
    logic [W-1:0] e_addr, e_wdata;
    logic         e_we;
    bit           done, to;
    int           n;
    e_addr   = own_d ? d_addr : i_addr;
    e_wdata  = d_wdata;
    e_we     = own_d ? d_we : 1'b0;
    m_last_d = own_d;
    tick;
    if (scramble) begin
      if (own_d) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = ~d_we;
      end else begin
        i_addr = $urandom;
      end
    end
    n    = 1;
    done = 0;
    while (!done) begin
      chk("mem_req_busy", {31'd0, mem_req}, 1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (own_d) chk("mem_wdata", mem_wdata, e_wdata);
      chk("ack_busy", {30'd0, i_ack, d_ack}, 0);
      mem_ack   = (n == lat);
      mem_rdata = (n == lat) ? rd : W'($urandom);
      tick;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (n == lat || n == TO + 1) done = 1;
      else n++;
    end
    to = (n != lat);
    if (!to) begin
      if (own_d) begin
        if (!e_we) m_drdata = rd;
      end else begin
        m_irdata = rd;
      end
    end
    chk("mem_req_done", {31'd0, mem_req}, 0);
    chk("acks", {30'd0, i_ack, d_ack}, {30'd0, !own_d, own_d});
    chk("errs", {30'd0, i_err, d_err}, {30'd0, !own_d && to, own_d && to});
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    if (own_d) d_req = 1'b0;
    else       i_req = 1'b0;
  endtask

  // One cycle with no requests, optionally with a stray mem_ack.
  task automatic idle_step(input bit stray);
    mem_ack = stray;
    tick;
    mem_ack = 1'b0;
    chk("idle_acks", {29'd0, mem_req, i_ack, d_ack}, 0);
  endtask

  task automatic run_scenario(input int pat, input int lat0, input int lat1);
    i_addr  = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_we    = 1'($urandom_range(0, 1));
    if (pat == 0) begin
      i_req = 1'b1;
      access(1'b0, lat0, $urandom, 1'b1);
    end else if (pat == 1) begin
      d_req = 1'b1;
      access(1'b1, lat0, $urandom, 1'b1);
    end else begin
      bit first_d;
      i_req   = 1'b1;
      d_req   = 1'b1;
      first_d = !m_last_d;
      access(first_d, lat0, $urandom, 1'b0);
      access(!first_d, lat1, $urandom, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] keep;
    rst = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    m_last_d = 0; m_irdata = 0; m_drdata = 0;
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b1;
    tick;

    // Reset in the middle of a data access: no ack, everything back to zero.
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h55;
    tick;
    chk("mid_grant", {31'd0, mem_req}, 1);
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk_all_zero("mid_rst");
    d_req = 0; d_we = 0;
    rst = 1'b1;
    m_last_d = 0;
    idle_step(1'b0);

    // Ties after reset go D first, then alternate.
    i_addr = 32'h100; d_addr = 32'h2000; d_we = 0; d_wdata = 0;
    i_req = 1; d_req = 1;
    access(1'b1, 2, 32'h1111_2222, 1'b0);
    access(1'b0, 1, 32'h3333_4444, 1'b0);
    idle_step(1'b0);
    i_req = 1; d_req = 1;
    access(1'b1, 4, 32'h5555_6666, 1'b0);
    access(1'b0, 2, 32'h7777_8888, 1'b0);
    idle_step(1'b1);

    // Plain fetch answered on the third mem_req cycle.
    i_req = 1; i_addr = 32'h100;
    access(1'b0, 3, 32'h0050_0093, 1'b0);
    chk("fetch_word", i_rdata, 32'h0050_0093);
    idle_step(1'b0);

    // Single-cycle store leaves load data untouched.
    keep = d_rdata;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    access(1'b1, 1, 32'hABCD_0123, 1'b0);
    chk("store_keeps_rdata", d_rdata, keep);
    idle_step(1'b0);

    // Memory never answers: 16 cycles of mem_req then ack+err.
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    access(1'b1, 1000, 32'h0, 1'b0);
    idle_step(1'b1);

    // mem_ack lands on the watchdog limit: data wins, no err.
    i_req = 1; i_addr = 32'h104;
    access(1'b0, TO + 1, 32'hCAFE_F00D, 1'b0);
    idle_step(1'b0);

    for (int s = 0; s < 40; s++) begin
      int pat, l0, l1;
      pat = $urandom_range(0, 2);
      l0  = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 16);
      l1  = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 16);
      run_scenario(pat, l0, l1);
      idle_step(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
